alu_seq: RTL and testbench

//  Parametrised multi-cycle ALU, next generation of the 16-bit ripple ALU. It adds WIDTH

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_comb.sv | 33 +++
 rtl/alu_seq.sv | 94 +++++++++
 tb/tb_alu_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and op-class helpers shared by the sequential ALU
package alu_pkg;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_NOR = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1100;
    localparam logic [3:0] OP_SLT = 4'b1101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return op == OP_SLL | op == OP_SRL | op == OP_SRA;
    endfunction
endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle datapath (logic ops, add/sub, SLT, carry/overflow); other ops give 0
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    logic             sub, arith, c, v;
    logic [WIDTH-1:0] bx, sum;

    assign sub      = op == OP_SUB | op == OP_SLT;
    assign arith    = op == OP_ADD | op == OP_SUB;
    assign bx       = sub ? ~b : b;
    assign {c, sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    // carry into the MSB is recovered from the MSB sum bit
    assign v        = a[WIDTH-1] ^ bx[WIDTH-1] ^ sum[WIDTH-1] ^ c;

    assign result = op == OP_AND ? a & b :
                    op == OP_OR  ? a | b :
                    op == OP_XOR ? a ^ b :
                    op == OP_NOR ? ~(a | b) :
                    arith        ? sum :
                    op == OP_SLT ? {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ v} :
                    '0;
    assign carry_out = arith & c;
    assign overflow  = arith & v;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes, bit-serial shifts and shift-add MUL
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               a_invert,
    input  logic [3:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow,
    output logic               carry_out
);
    localparam int CW = SHAMT_W + 1;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_eff, res, step, mcand, mplier, comb_res;
    logic             comb_c, comb_v, cf, vf, accept, multi;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a         (a_eff),
        .b         (b),
        .op        (op),
        .result    (comb_res),
        .carry_out (comb_c),
        .overflow  (comb_v)
    );

    assign a_eff    = a_invert ? ~a : a;
    assign multi    = op == OP_MUL | (is_shift(op) & |shamt);
    assign in_ready = state == IDLE | (state == DONE & out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_nx = state;
        if (state == BUSY) state_nx = cnt == CW'(1) ? DONE : BUSY;
        else if (accept) state_nx = multi ? BUSY : DONE;
        else if (state == DONE & out_ready) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // res doubles as the shift register and the MUL accumulator
    assign step = op_q == OP_MUL ? (mplier[0] ? res + mcand : res) :
                  op_q == OP_SLL ? res << 1 :
                  op_q == OP_SRL ? res >> 1 :
                  {res[WIDTH-1], res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res    <= '0;
            cf     <= 1'b0;
            vf     <= 1'b0;
            cnt    <= '0;
            op_q   <= OP_AND;
            mcand  <= '0;
            mplier <= '0;
        end else if (accept) begin
            op_q   <= op;
            cnt    <= op == OP_MUL ? CW'(WIDTH) : CW'(shamt);
            res    <= op == OP_MUL ? '0 : is_shift(op) ? a_eff : comb_res;
            cf     <= comb_c;
            vf     <= comb_v;
            mcand  <= a_eff;
            mplier <= b;
        end else if (state == BUSY) begin
            cnt    <= cnt - CW'(1);
            res    <= step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign out_valid = state == DONE;
    assign result    = res;
    assign zero      = out_valid & ~|res;
    assign carry_out = cf;
    assign overflow  = vf;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq checked by literals and a cycle-level reference model
module tb_alu_seq;
    logic        clk = 0, rst_n = 0, in_valid = 0, a_invert = 0, out_ready = 1;
    logic [15:0] a = 0, b = 0;
    logic [3:0]  op = 0, shamt = 0;
    logic        in_ready, out_valid, zero, overflow, carry_out;
    logic [15:0] result;
    int          checks = 0, errors = 0;
    bit          en = 0;

    int          m_wait = 0;
    logic        m_valid = 0, m_c = 0, m_v = 0, acc;
    logic [15:0] m_res = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_invert  (a_invert),
        .op        (op),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference: result from signed/unsigned arithmetic, delay in extra cycles after accept
    function automatic void calc(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                                 input logic inv, input logic [3:0] sh,
                                 output logic [15:0] r, output logic c, output logic v, output int d);
        logic [15:0] ae;
        logic [16:0] s;
        logic [31:0] p;
        int sa, sb;
        ae = inv ? ~x : x;
        sa = $signed(ae);
        sb = $signed(y);
        r = 0; c = 0; v = 0; d = 0;
        case (o)
            4'b0000: r = ae & y;
            4'b0001: r = ae | y;
            4'b0010: r = ae ^ y;
            4'b0011: r = ~(ae | y);
            4'b0100: begin s = ae + y; r = s[15:0]; c = s[16]; v = (sa + sb > 32767) || (sa + sb < -32768); end
            4'b1100: begin s = {1'b0, ae} + {1'b0, ~y} + 17'd1; r = s[15:0]; c = s[16]; v = (sa - sb > 32767) || (sa - sb < -32768); end
            4'b1101: r = (sa < sb) ? 16'd1 : 16'd0;
            4'b0101: begin r = ae << sh; d = sh; end
            4'b0110: begin r = ae >> sh; d = sh; end
            4'b0111: begin r = $signed(ae) >>> sh; d = sh; end
            4'b1000: begin p = ae * y; r = p[15:0]; d = 16; end
            default: r = 0;
        endcase
    endfunction

    always @(posedge clk) begin
        int d;
        if (!rst_n) begin
            m_wait = 0; m_valid = 0; m_res = 0; m_c = 0; m_v = 0;
        end else begin
            acc = in_valid && m_wait == 0 && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 0;
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_valid = 1;
            end else if (acc) begin
                calc(op, a, b, a_invert, shamt, m_res, m_c, m_v, d);
                m_wait = d;
                if (d == 0) m_valid = 1;
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (en) begin
            chk("cmp_in_ready", in_ready, m_wait == 0 && (!m_valid || out_ready));
            chk("cmp_out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("cmp_result", result, m_res);
                chk("cmp_zero", zero, m_res == 0);
                chk("cmp_carry", carry_out, m_c);
                chk("cmp_overflow", overflow, m_v);
            end
        end
    end

    task automatic run(input string name, input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic inv, input logic [3:0] sh, input int lat_exp, input logic [15:0] r_exp,
                       input logic c_exp, input logic v_exp, input logic z_exp);
        int n, lat;
        @(negedge clk);
        op = o; a = x; b = y; a_invert = inv; shamt = sh; in_valid = 1;
        #1;
        n = 0;
        while (!in_ready && n < 40) begin @(negedge clk); #1; n++; end
        chk({name, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 0; a = ~x; b = ~y; op = ~o; shamt = ~sh; a_invert = ~inv;
        lat = 1;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
        chk({name, "_latency"}, lat, lat_exp);
        chk({name, "_result"}, result, r_exp);
        chk({name, "_carry"}, carry_out, c_exp);
        chk({name, "_overflow"}, overflow, v_exp);
        chk({name, "_zero"}, zero, z_exp);
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        en = 1;
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_flags", {carry_out, overflow}, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1;

        run("add",     4'b0100, 16'd100,   16'd85,    0, 0,  1,  16'd185,   0, 0, 0);
        run("sub",     4'b1100, 16'd100,   16'd95,    0, 0,  1,  16'd5,     1, 0, 0);
        run("add_ovf", 4'b0100, 16'h7FFF,  16'h0001,  0, 0,  1,  16'h8000,  0, 1, 0);
        run("slt",     4'b1101, 16'h8000,  16'h0001,  0, 0,  1,  16'd1,     0, 0, 0);
        run("sub_eq",  4'b1100, 16'd5,     16'd5,     0, 0,  1,  16'd0,     1, 0, 1);
        run("sub_brw", 4'b1100, 16'd0,     16'd1,     0, 0,  1,  16'hFFFF,  0, 0, 0);
        run("sra",     4'b0111, 16'h8010,  16'h0000,  0, 4,  5,  16'hF801,  0, 0, 0);
        run("sll0",    4'b0101, 16'h1234,  16'h0000,  0, 0,  1,  16'h1234,  0, 0, 0);
        run("srl15",   4'b0110, 16'h8000,  16'h0000,  0, 15, 16, 16'h0001,  0, 0, 0);
        run("mul",     4'b1000, 16'd300,   16'd7,     0, 0,  17, 16'd2100,  0, 0, 0);
        run("mul_z",   4'b1000, 16'h0100,  16'h0100,  0, 0,  17, 16'h0000,  0, 0, 1);
        run("and",     4'b0000, 16'hF0F0,  16'h3C3C,  0, 0,  1,  16'h3030,  0, 0, 0);
        run("or",      4'b0001, 16'hF0F0,  16'h0F0F,  0, 0,  1,  16'hFFFF,  0, 0, 0);
        run("xor",     4'b0010, 16'hAAAA,  16'hFFFF,  0, 0,  1,  16'h5555,  0, 0, 0);
        run("nor",     4'b0011, 16'h0000,  16'h0000,  0, 0,  1,  16'hFFFF,  0, 0, 0);
        run("add_inv", 4'b0100, 16'h0005,  16'h0006,  1, 0,  1,  16'h0000,  1, 0, 1);
        run("illegal", 4'b1010, 16'h1234,  16'h5678,  0, 0,  1,  16'h0000,  0, 0, 1);

        @(negedge clk);
        out_ready = 0; op = 4'b0100; a = 16'd3; b = 16'd4; a_invert = 0; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        #1;
        chk("stall_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_result", result, 16'd7);
            chk("stall_valid_held", out_valid, 1);
        end
        @(negedge clk);
        out_ready = 1; in_valid = 1; op = 4'b0010; a = 16'h00FF; b = 16'h0F0F;
        #1;
        chk("b2b_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        #1;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_result", result, 16'h0FF0);

        @(negedge clk);
        op = 4'b1000; a = 16'd300; b = 16'd7; in_valid = 1;
        @(negedge clk);
        op = 4'b0100; a = 16'd1; b = 16'd1;
        lat = 1;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
        chk("busy_ign_latency", lat, 17);
        chk("busy_ign_result", result, 16'd2100);
        @(negedge clk);
        in_valid = 0;
        #1;
        chk("busy_next_valid", out_valid, 1);
        chk("busy_next_result", result, 16'd2);

        @(negedge clk);
        op = 4'b1000; a = 16'd300; b = 16'd7; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (5) @(negedge clk);
        #1;
        chk("mid_busy_in_ready", in_ready, 0);
        rst_n = 0;
        @(negedge clk);
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_flags", {zero, carry_out, overflow}, 0);
        rst_n = 1;
        run("post_rst", 4'b0100, 16'd1, 16'd2, 0, 0, 1, 16'd3, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
